// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encodings and the 2:1 word select used by the memory-port arbiter.
// Pure definitions, no state.
// No flow control of its own.
package mem_port_arbiter_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Same select the memory datapath uses: 0 picks fetch, 1 picks load/store.
    function automatic logic [WORD-1:0] word_sel2(input logic sel,
                                                  input logic [WORD-1:0] w0,
                                                  input logic [WORD-1:0] w1);
        return sel ? w1 : w0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, bus and select signals of the memory-port arbiter.
// Wiring only, no latency.
// Handshakes are req/ack; the bus side holds its command until bus_ack.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD = mem_port_arbiter_pkg::WORD
);
    logic            r0_req;
    logic [WORD-1:0] r0_addr;
    logic [WORD-1:0] r0_wdata;
    logic            r0_we;
    logic            r0_ack;
    logic [WORD-1:0] r0_rdata;

    logic            r1_req;
    logic [WORD-1:0] r1_addr;
    logic [WORD-1:0] r1_wdata;
    logic            r1_we;
    logic            r1_ack;
    logic [WORD-1:0] r1_rdata;

    logic            bus_req;
    logic [WORD-1:0] bus_addr;
    logic [WORD-1:0] bus_wdata;
    logic            bus_we;
    logic            bus_ack;
    logic [WORD-1:0] bus_rdata;

    logic            grant_sel;

    // master is the arbiter; slave is the requesters plus memory
    modport master (
        input  r0_req, r0_addr, r0_wdata, r0_we,
        input  r1_req, r1_addr, r1_wdata, r1_we,
        input  bus_ack, bus_rdata,
        output r0_ack, r0_rdata, r1_ack, r1_rdata,
        output bus_req, bus_addr, bus_wdata, bus_we, grant_sel
    );

    modport slave (
        output r0_req, r0_addr, r0_wdata, r0_we,
        output r1_req, r1_addr, r1_wdata, r1_we,
        output bus_ack, bus_rdata,
        input  r0_ack, r0_rdata, r1_ack, r1_rdata,
        input  bus_req, bus_addr, bus_wdata, bus_we, grant_sel
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not granted last.
// Combinational, zero latency.
// No backpressure; the caller decides when to act on the pick.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;
    assign gnt_id    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (0) and load/store (1) with round-robin grants.
// Latency: grant -> bus_req next cycle; bus_ack in k -> rX_ack/rX_rdata in k+1; idle again k+2.
// Backpressure: the granted command is held on the bus until bus_ack; the loser simply waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD = mem_port_arbiter_pkg::WORD
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.master  port
);

    state_t          state;
    logic            last_grant;
    logic            pick_vld;
    logic            pick_id;
    logic [WORD-1:0] sel_addr;
    logic [WORD-1:0] sel_wdata;
    logic            sel_we;

    logic            bus_req_q, bus_we_q, grant_sel_q;
    logic [WORD-1:0] bus_addr_q, bus_wdata_q;
    logic            r0_ack_q, r1_ack_q;
    logic [WORD-1:0] r0_rdata_q, r1_rdata_q;

    rr_pick2 u_pick (
        .req0      (port.r0_req),
        .req1      (port.r1_req),
        .last      (last_grant),
        .gnt_valid (pick_vld),
        .gnt_id    (pick_id)
    );

    assign sel_addr  = word_sel2(pick_id, port.r0_addr,  port.r1_addr);
    assign sel_wdata = word_sel2(pick_id, port.r0_wdata, port.r1_wdata);
    assign sel_we    = pick_id ? port.r1_we : port.r0_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            grant_sel_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        bus_addr_q  <= sel_addr;
                        bus_wdata_q <= sel_wdata;
                        bus_we_q    <= sel_we;
                        grant_sel_q <= pick_id;
                        last_grant  <= pick_id;
                        bus_req_q   <= 1'b1;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // ack is raised here so it is visible during DONE, one cycle after bus_ack
                    if (port.bus_ack) begin
                        if (grant_sel_q) begin
                            r1_rdata_q <= port.bus_rdata;
                            r1_ack_q   <= 1'b1;
                        end else begin
                            r0_rdata_q <= port.bus_rdata;
                            r0_ack_q   <= 1'b1;
                        end
                        bus_req_q <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign port.bus_req   = bus_req_q;
    assign port.bus_addr  = bus_addr_q;
    assign port.bus_wdata = bus_wdata_q;
    assign port.bus_we    = bus_we_q;
    assign port.grant_sel = grant_sel_q;
    assign port.r0_ack    = r0_ack_q;
    assign port.r1_ack    = r1_ack_q;
    assign port.r0_rdata  = r0_rdata_q;
    assign port.r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, lone fetch, contention, store, stray ack, reset abort, early drop.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .port (bus_if)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_done(input logic [31:0] d);
        bus_if.bus_rdata = d;
        bus_if.bus_ack   = 1'b1;
        tick();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_if.r0_req = 0; bus_if.r0_addr = '0; bus_if.r0_wdata = '0; bus_if.r0_we = 0;
        bus_if.r1_req = 0; bus_if.r1_addr = '0; bus_if.r1_wdata = '0; bus_if.r1_we = 0;
        bus_if.bus_ack = 0; bus_if.bus_rdata = '0;

        // reset state
        tick(); tick();
        chk("rst_bus_req",   32'(bus_if.bus_req),   0);
        chk("rst_bus_we",    32'(bus_if.bus_we),    0);
        chk("rst_grant_sel", 32'(bus_if.grant_sel), 0);
        chk("rst_r0_ack",    32'(bus_if.r0_ack),    0);
        chk("rst_r1_ack",    32'(bus_if.r1_ack),    0);
        chk("rst_bus_addr",  bus_if.bus_addr,  0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 0);
        chk("rst_r0_rdata",  bus_if.r0_rdata,  0);
        chk("rst_r1_rdata",  bus_if.r1_rdata,  0);
        rstn = 1'b1;

        // lone fetch, bus_ack two cycles after bus_req
        bus_if.r0_req  = 1;
        bus_if.r0_addr = 32'h1C00_0000;
        tick();
        chk("f_bus_req",   32'(bus_if.bus_req),   1);
        chk("f_bus_addr",  bus_if.bus_addr,       32'h1C00_0000);
        chk("f_bus_we",    32'(bus_if.bus_we),    0);
        chk("f_grant_sel", 32'(bus_if.grant_sel), 0);
        tick();
        chk("f_hold_req",  32'(bus_if.bus_req),   1);
        tick();
        bus_done(32'h0280_0000);
        chk("f_r0_ack",    32'(bus_if.r0_ack),    1);
        chk("f_r0_rdata",  bus_if.r0_rdata,       32'h0280_0000);
        chk("f_r1_ack",    32'(bus_if.r1_ack),    0);
        chk("f_req_drop",  32'(bus_if.bus_req),   0);
        bus_if.r0_req = 0;
        tick();
        chk("f_ack_once",  32'(bus_if.r0_ack),    0);

        // contention straight after reset: 0,1,0,1
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        bus_if.r0_req = 1; bus_if.r0_addr = 32'h0000_00A0;
        bus_if.r1_req = 1; bus_if.r1_addr = 32'h0000_00B0;
        for (int i = 0; i < 4; i++) begin
            logic exp_g;
            exp_g = i[0];
            tick();
            chk($sformatf("rr%0d_grant", i), 32'(bus_if.grant_sel), 32'(exp_g));
            chk($sformatf("rr%0d_addr", i),  bus_if.bus_addr, exp_g ? 32'h0000_00B0 : 32'h0000_00A0);
            bus_done(32'h1000 + 32'(i));
            if (exp_g) begin
                chk($sformatf("rr%0d_ack", i),   32'(bus_if.r1_ack), 1);
                chk($sformatf("rr%0d_other", i), 32'(bus_if.r0_ack), 0);
                chk($sformatf("rr%0d_rdata", i), bus_if.r1_rdata, 32'h1000 + 32'(i));
            end else begin
                chk($sformatf("rr%0d_ack", i),   32'(bus_if.r0_ack), 1);
                chk($sformatf("rr%0d_other", i), 32'(bus_if.r1_ack), 0);
                chk($sformatf("rr%0d_rdata", i), bus_if.r0_rdata, 32'h1000 + 32'(i));
            end
            tick();
        end
        bus_if.r0_req = 0; bus_if.r1_req = 0;
        tick();
        chk("rr_idle_req", 32'(bus_if.bus_req), 0);

        // store held stable through a long memory wait
        bus_if.r1_req = 1; bus_if.r1_we = 1;
        bus_if.r1_addr = 32'h0000_0100; bus_if.r1_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_grant", 32'(bus_if.grant_sel), 1);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("st%0d_req", j),   32'(bus_if.bus_req), 1);
            chk($sformatf("st%0d_we", j),    32'(bus_if.bus_we),  1);
            chk($sformatf("st%0d_addr", j),  bus_if.bus_addr,  32'h0000_0100);
            chk($sformatf("st%0d_wdata", j), bus_if.bus_wdata, 32'hDEAD_BEEF);
            chk($sformatf("st%0d_noack", j), 32'(bus_if.r1_ack), 0);
            tick();
        end
        bus_done(32'h55AA_55AA);
        chk("st_r1_ack", 32'(bus_if.r1_ack), 1);
        chk("st_r0_ack", 32'(bus_if.r0_ack), 0);
        bus_if.r1_req = 0; bus_if.r1_we = 0;
        tick();
        chk("st_ack_once", 32'(bus_if.r1_ack), 0);
        tick();
        chk("st_idle_req", 32'(bus_if.bus_req), 0);

        // stray bus_ack while idle
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        bus_if.bus_ack = 1;
        tick();
        bus_if.bus_ack = 0; bus_if.bus_rdata = '0;
        chk("stray_req",    32'(bus_if.bus_req), 0);
        chk("stray_r0_ack", 32'(bus_if.r0_ack),  0);
        chk("stray_r1_ack", 32'(bus_if.r1_ack),  0);
        tick();
        chk("stray_r0_ack2", 32'(bus_if.r0_ack), 0);
        chk("stray_r1_ack2", 32'(bus_if.r1_ack), 0);
        chk("stray_rdata",   bus_if.r1_rdata,    32'h55AA_55AA);

        // reset while busy
        bus_if.r1_req = 1; bus_if.r1_addr = 32'h0000_0200;
        tick();
        chk("rb_req", 32'(bus_if.bus_req), 1);
        #1 rstn = 1'b0;
        #1;
        chk("rb_async_drop", 32'(bus_if.bus_req), 0);
        chk("rb_addr_clr",   bus_if.bus_addr,     0);
        bus_if.r1_req = 0;
        tick();
        tick();
        chk("rb_no_ack1", 32'(bus_if.r1_ack), 0);
        chk("rb_no_ack0", 32'(bus_if.r0_ack), 0);
        rstn = 1'b1;
        bus_if.r0_req = 1; bus_if.r0_addr = 32'h0000_0300;
        bus_if.r1_req = 1; bus_if.r1_addr = 32'h0000_0400;
        tick();
        chk("rb_first_grant", 32'(bus_if.grant_sel), 0);
        chk("rb_first_addr",  bus_if.bus_addr,       32'h0000_0300);
        bus_done(32'h0000_0077);
        chk("rb_r0_ack", 32'(bus_if.r0_ack), 1);
        bus_if.r0_req = 0; bus_if.r1_req = 0;
        tick();

        // load/store drops req right after grant
        bus_if.r1_req = 1; bus_if.r1_addr = 32'h0000_0500;
        tick();
        chk("ed_grant", 32'(bus_if.grant_sel), 1);
        bus_if.r1_req = 0;
        tick();
        tick();
        chk("ed_hold_req", 32'(bus_if.bus_req), 1);
        chk("ed_hold_addr", bus_if.bus_addr,    32'h0000_0500);
        bus_done(32'hCAFE_F00D);
        chk("ed_r1_ack",   32'(bus_if.r1_ack), 1);
        chk("ed_r1_rdata", bus_if.r1_rdata,    32'hCAFE_F00D);
        tick();
        chk("ed_ack_once", 32'(bus_if.r1_ack), 0);
        chk("ed_idle_req", 32'(bus_if.bus_req), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
